// File: rtl/vinst_sched_if.sv
// Shared instruction type plus the scheduler's handshake bundle.
// master: host/sequencer/vinst_ctl side; slave: vinst_sched.
package vinst_sched_pkg;

    localparam int LAP_N = 8;

    typedef struct packed {
        logic [7:0]       op;
        logic [31:0]      aadr;
        logic [31:0]      badr;
        logic [31:0]      cadr;
        logic [LAP_N-1:0] vsize;
    } sa_inst_t;

endpackage

interface vinst_sched_if #(
    parameter int CNT_W = 16
);
    import vinst_sched_pkg::*;

    sa_inst_t         h_inst;
    logic             h_valid;
    logic             h_ready;
    sa_inst_t         s_inst;
    logic             s_valid;
    logic             s_ready;
    logic             flush;
    sa_inst_t         inst;
    logic             iavail;
    logic             ird;
    logic             busy;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output h_inst, h_valid, s_inst, s_valid, flush, ird,
        input  h_ready, s_ready, inst, iavail, busy,
        input  issue_cnt, stall_cnt
    );

    modport slave (
        input  h_inst, h_valid, s_inst, s_valid, flush, ird,
        output h_ready, s_ready, inst, iavail, busy,
        output issue_cnt, stall_cnt
    );

endinterface

// File: rtl/vinst_sched.sv
// Two-source vector-instruction scheduler in front of vinst_ctl.
// Round-robin host/sequencer arbitration into a DEPTH-entry FIFO,
// head issued over iavail/ird, held back on a C-range hazard
// against the single in-flight instruction (scoreboard).
// Ports: clk, reset (sync, active high), bus (vinst_sched_if.slave):
//   h_inst/h_valid/h_ready, s_inst/s_valid/s_ready, flush,
//   inst/iavail/ird, busy, issue_cnt/stall_cnt.
// Option: define VSCHED_STATS_EN for saturating issue/stall counters;
//   otherwise both counters read 0.
module vinst_sched
    import vinst_sched_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PIPE_LAT = 3,
    parameter int ADR_W    = 16,
    parameter int CNT_W    = 16
) (
    input logic           clk,
    input logic           reset,
    vinst_sched_if.slave  bus
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int SB_W = $clog2((1 << LAP_N) + PIPE_LAT);
    localparam int SW   = ADR_W + 1;

    sa_inst_t         mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             rr;

    logic [ADR_W-1:0] sb_lo;
    logic [LAP_N-1:0] sb_len;
    logic [SB_W-1:0]  sb_cnt;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             hazard;
    logic             sb_live;
    sa_inst_t         head;
    sa_inst_t         push_inst;
    logic [SW-1:0]    sb_hi;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign sb_live = (sb_cnt != '0);

    // rr=0: host has priority, rr=1: sequencer has priority.
    assign bus.h_ready = !full && !bus.flush && !reset && bus.h_valid
                       && (!rr || !bus.s_valid);
    assign bus.s_ready = !full && !bus.flush && !reset && bus.s_valid
                       && (rr || !bus.h_valid);

    assign push      = bus.h_ready || bus.s_ready;
    assign push_inst = bus.h_ready ? bus.h_inst : bus.s_inst;

    // Inclusive ranges, one extra bit so the upper bounds never wrap.
    assign sb_hi = {1'b0, sb_lo} + SW'(sb_len);

    function automatic logic overlap(
        input logic [ADR_W-1:0] x,
        input logic [LAP_N-1:0] n,
        input logic [ADR_W-1:0] lo,
        input logic [SW-1:0]    hi
    );
        logic [SW-1:0] x_hi;
        x_hi = {1'b0, x} + SW'(n);
        return ({1'b0, x} <= hi) && ({1'b0, lo} <= x_hi);
    endfunction

    assign hazard = sb_live && (
        overlap(head.aadr[ADR_W-1:0], head.vsize, sb_lo, sb_hi) ||
        overlap(head.badr[ADR_W-1:0], head.vsize, sb_lo, sb_hi));

    assign bus.inst   = head;
    assign bus.iavail = !empty && !hazard && !bus.flush && !reset;
    assign pop        = bus.ird && bus.iavail;
    assign bus.busy   = !empty || sb_live;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_inst;
                rr          <= bus.h_ready;
            end
            if (bus.flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Single-entry scoreboard: a new issue replaces the old one.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_lo  <= '0;
            sb_len <= '0;
            sb_cnt <= '0;
        end else if (pop) begin
            sb_lo  <= head.cadr[ADR_W-1:0];
            sb_len <= head.vsize;
            sb_cnt <= SB_W'(head.vsize) + SB_W'(PIPE_LAT);
        end else if (sb_live) begin
            sb_cnt <= sb_cnt - 1'b1;
        end
    end

`ifdef VSCHED_STATS_EN
    logic [CNT_W-1:0] issue_q;
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_q <= '0;
            stall_q <= '0;
        end else begin
            if (pop && issue_q != '1) begin
                issue_q <= issue_q + 1'b1;
            end
            if (!empty && hazard && stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign bus.issue_cnt = issue_q;
    assign bus.stall_cnt = stall_q;
`else
    assign bus.issue_cnt = '0;
    assign bus.stall_cnt = '0;
`endif

endmodule
